// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Saturation limits are returned sign-extended to MaxN bits; callers slice the low N bits.
package pipe_addsub_pkg;

  localparam int unsigned DefaultN      = 32;
  localparam int unsigned DefaultStages = 4;
  localparam int unsigned MaxN          = 64;

  function automatic int unsigned chunk_width(input int unsigned n, input int unsigned stages);
    return n / stages;
  endfunction

  // Largest positive value, 2^(n-1)-1.
  function automatic logic [MaxN-1:0] sat_pos(input int unsigned n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative value, -2^(n-1).
  function automatic logic [MaxN-1:0] sat_neg(input int unsigned n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i >= n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// One W-bit ripple-carry slice of the pipelined adder; also exposes the carry
// into its MSB so the top slice can derive signed overflow.
module addsub_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[W];
  assign msb_cin = c[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined signed add/subtract, one N/STAGES-bit chunk resolved per stage, valid/ready flow control.
// Optional feature: define SATURATE_EN to clamp Z to the signed range on overflow.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned N      = DefaultN,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         overflow,
  output logic         carry
);

  localparam int unsigned W = chunk_width(N, STAGES);

  logic                       advance;
  logic [N-1:0]               y_eff;

  // Stage inputs (*_in) and stage registers (*_q); index k is stage k.
  logic [STAGES-1:0]          v_in, v_q;
  logic [STAGES-1:0][N-1:0]   x_in, x_q;
  logic [STAGES-1:0][N-1:0]   y_in, y_q;
  logic [STAGES-1:0][N-1:0]   z_in, z_q, nxt_z;
  logic [STAGES-1:0]          c_in, c_q;
  logic [STAGES-1:0][W-1:0]   sum;
  logic [STAGES-1:0]          cout;
  logic [STAGES-1:0]          msb_cin;
  logic                       nxt_ovf, ovf_q;

  // The whole pipe freezes only when a finished result is being refused.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign y_eff    = sub ? ~Y : Y;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] z_mix;

    if (k == 0) begin : g_head
      assign v_in[k] = in_valid;
      assign x_in[k] = X;
      assign y_in[k] = y_eff;
      assign z_in[k] = '0;
      assign c_in[k] = sub;
    end else begin : g_body
      assign v_in[k] = v_q[k-1];
      assign x_in[k] = x_q[k-1];
      assign y_in[k] = y_q[k-1];
      assign z_in[k] = z_q[k-1];
      assign c_in[k] = c_q[k-1];
    end

    addsub_chunk #(
      .W(W)
    ) u_chunk (
      .a      (x_in[k][k*W +: W]),
      .b      (y_in[k][k*W +: W]),
      .cin    (c_in[k]),
      .sum    (sum[k]),
      .cout   (cout[k]),
      .msb_cin(msb_cin[k])
    );

    always_comb begin
      z_mix              = z_in[k];
      z_mix[k*W +: W]    = sum[k];
    end

    if (k == STAGES - 1) begin : g_tail
      logic ovf;
      assign ovf     = msb_cin[k] ^ cout[k];
      assign nxt_ovf = ovf;
`ifdef SATURATE_EN
      localparam logic [MaxN-1:0] SatPos = sat_pos(N);
      localparam logic [MaxN-1:0] SatNeg = sat_neg(N);
      // On overflow both operands share X's sign, which picks the clamp direction.
      assign nxt_z[k] = !ovf ? z_mix : (x_in[k][N-1] ? SatNeg[N-1:0] : SatPos[N-1:0]);
`else
      assign nxt_z[k] = z_mix;
`endif
    end else begin : g_mid
      assign nxt_z[k] = z_mix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q   <= v_in;
      x_q   <= x_in;
      y_q   <= y_in;
      z_q   <= nxt_z;
      c_q   <= cout;
      ovf_q <= nxt_ovf;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign Z         = z_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign overflow  = ovf_q;

  // Operand copies in the last stage and intermediate MSB carries have no consumer.
  logic unused_bits;
  assign unused_bits = ^{x_q[STAGES-1], y_q[STAGES-1], msb_cin};

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width in bits; N >= 2.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; 1 <= STAGES <= N; N % STAGES == 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: X/Y/sub carry a valid operation this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operation this cycle.
REQ-007 SHALL have ports X and Y, input, N each: signed two's-complement operands.
REQ-008 SHALL have port sub, input, 1: 0 = X+Y, 1 = X-Y.
REQ-009 SHALL have port out_valid, output, 1: Z/overflow/carry hold a valid result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result this cycle.
REQ-011 SHALL have port Z, output, N: signed result.
REQ-012 SHALL have port overflow, output, 1: signed overflow of the operation.
REQ-013 SHALL have port carry, output, 1: unsigned carry-out of the MSB (for X-Y: no-borrow).

Function
REQ-014 SHALL compute Z = X + (sub ? ~Y : Y) + sub, truncated to N bits.
REQ-015 SHALL set overflow when both effective operands share a sign and Z's sign differs from it.
REQ-016 SHALL split the add into STAGES chunks of N/STAGES bits: chunk k resolved in stage k, carry registered into stage k+1, unresolved upper operand bits registered alongside.
REQ-017 SHALL give latency exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, when no stall occurs.
REQ-018 SHALL sustain one accepted operation per cycle when out_ready is held high.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready); the whole pipeline freezes while that term is low.
REQ-020 SHALL keep Z, overflow, carry and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL propagate a per-stage valid bit; bubbles (in_valid low) SHALL produce out_valid low in the matching output cycle.
REQ-022 SHALL ignore X, Y and sub in cycles where in_valid && in_ready is false.
REQ-023 SHALL deliver results in acceptance order, with none lost or duplicated.

Reset
REQ-024 SHALL on rst clear every stage valid bit, out_valid=0, Z=0, overflow=0, carry=0, while in_ready=1.
REQ-025 SHALL give rst priority over in_valid and out_ready in the same cycle; in-flight operations are discarded and any input presented that cycle is not accepted.
REQ-026 SHALL accept a new input on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with SATURATE_EN defined, clamp Z to 2^(N-1)-1 on positive overflow and to -2^(N-1) on negative overflow, with overflow still asserted.
REQ-028 SHALL, without SATURATE_EN, output the wrapped Z of REQ-014 with no extra logic or latency.

Structure
REQ-029 SHALL place stage-count and chunk-width helper constants and the saturation limit functions in shared package pipe_addsub_pkg.
REQ-030 SHALL implement one chunk as sub-module addsub_chunk (W-bit ripple add with carry-in; outputs sum, carry-out, MSB carry-in for overflow), instantiated STAGES times.

Verification (N=8, STAGES=4, out_ready=1 unless stated)
REQ-031 SHALL check X=100, Y=27, sub=0 -> Z=127, overflow=0, carry=0, 4 cycles after acceptance.
REQ-032 SHALL check X=100, Y=28, sub=0 -> overflow=1; Z=-128 without SATURATE_EN, Z=127 with it.
REQ-033 SHALL check X=-128, Y=1, sub=1 -> overflow=1, carry=1; Z=127 without SATURATE_EN, Z=-128 with it; and X=5, Y=5, sub=1 -> Z=0, carry=1, overflow=0.
REQ-034 SHALL check 8 back-to-back operations with out_ready=0 from cycle 3 to 7 -> in_ready low in exactly the stalled cycles, held result stable, all 8 results in order, none lost.
REQ-035 SHALL check alternating in_valid 1/0 -> out_valid alternates 1/0 with latency 4.
REQ-036 SHALL check rst asserted with 3 operations in flight -> out_valid=0 and Z=0 on the next cycle, no stale result emerges afterwards, and the first post-reset input yields its correct result.
